// File: rtl/avmm_key_sw_capture.sv
// Avalon-MM responder for board pushbuttons and slide switches.
// Raw pins pass through a two-flop synchroniser and a per-bit debouncer.
// Key press and release edges are latched into write-1-to-clear capture
// registers, and a maskable level interrupt is raised from the press captures.

// Per-bit debouncer bank. A new level is accepted once the synchronised input
// has disagreed with the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module avmm_key_sw_capture_debounce #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  input  logic [W-1:0] sync_in,
  output logic [W-1:0] stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [W];

  // Count disagreement cycles per bit; accept the new level on the last count.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stable <= '0;
      // NOTE: the counter array is reset on purpose: a half-counted
      // disagreement must not survive reset and shorten the next debounce.
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (sync_in[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_in[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

module avmm_key_sw_capture #(
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_SW-1:0]   sw,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  typedef enum logic [2:0] {
    ADDR_KEY_STATE   = 3'd0,
    ADDR_SW_STATE    = 3'd1,
    ADDR_IRQ_MASK    = 3'd2,
    ADDR_PRESS_CAP   = 3'd3,
    ADDR_RELEASE_CAP = 3'd4,
    ADDR_INFO        = 3'd5
  } reg_addr_e;

  localparam logic [31:0] INFO_WORD = {8'hA5, 8'(N_SW), 8'(N_KEYS), 8'h01};

  logic [N_KEYS-1:0] key_meta, key_sync;
  logic [N_SW-1:0]   sw_meta, sw_sync;
  logic [N_KEYS-1:0] key_stable, key_stable_d;
  logic [N_SW-1:0]   sw_stable;
  logic [N_KEYS-1:0] irq_mask, press_cap, release_cap;
  logic [N_KEYS-1:0] press_evt, release_evt, press_clr, release_clr;
  logic [31:0]       rd_mux;

  // Two-flop synchronisers; keys idle high so their flops reset to 1.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      key_meta <= '1;
      key_sync <= '1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      // NOTE: non-blocking assignments make the two stages a real pipeline;
      // blocking ones would collapse the synchroniser into a single flop.
      key_meta <= key_n;
      key_sync <= key_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  avmm_key_sw_capture_debounce #(
    .W               (N_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key_db (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .sync_in     (~key_sync),
    .stable      (key_stable)
  );

  avmm_key_sw_capture_debounce #(
    .W               (N_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw_db (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .sync_in     (sw_sync),
    .stable      (sw_stable)
  );

  // Edge detection and write-1-to-clear decode for the capture registers.
  always_comb begin
    press_evt   = key_stable & ~key_stable_d;
    release_evt = ~key_stable & key_stable_d;
    press_clr   = '0;
    release_clr = '0;
    if (avs_write && (avs_address == ADDR_PRESS_CAP))
      press_clr = avs_writedata[N_KEYS-1:0];
    if (avs_write && (avs_address == ADDR_RELEASE_CAP))
      release_clr = avs_writedata[N_KEYS-1:0];
  end

  // Control/status registers; a new event on a bit wins over its clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      key_stable_d <= '0;
      irq_mask     <= '0;
      press_cap    <= '0;
      release_cap  <= '0;
    end else begin
      key_stable_d <= key_stable;
      press_cap    <= (press_cap & ~press_clr) | press_evt;
      release_cap  <= (release_cap & ~release_clr) | release_evt;
      if (avs_write && (avs_address == ADDR_IRQ_MASK))
        irq_mask <= avs_writedata[N_KEYS-1:0];
    end
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch forms.
    rd_mux = '0;
    case (reg_addr_e'(avs_address))
      ADDR_KEY_STATE:   rd_mux = 32'(key_stable);
      ADDR_SW_STATE:    rd_mux = 32'(sw_stable);
      ADDR_IRQ_MASK:    rd_mux = 32'(irq_mask);
      ADDR_PRESS_CAP:   rd_mux = 32'(press_cap);
      ADDR_RELEASE_CAP: rd_mux = 32'(release_cap);
      ADDR_INFO:        rd_mux = INFO_WORD;
      default:          rd_mux = '0;
    endcase
  end

  // Registered read data (zero when not reading) and registered interrupt.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      avs_readdata <= avs_read ? rd_mux : 32'd0;
      irq          <= |(press_cap & irq_mask);
    end
  end

endmodule
